// File: rtl/branch_ctrl_if.sv
// Bundled instruction, result, redirect and statistics signals of the
// execute-stage branch controller; the comparator op encoding lives here too.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_OP_SEQ
`define ALU_OP_SEQ  4'hA
`define ALU_OP_SNE  4'hB
`define ALU_OP_SLT  4'h2
`define ALU_OP_SLTU 4'h3
`define ALU_OP_SGE  4'hC
`define ALU_OP_SGEU 4'hD
`endif

interface branch_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [XLEN-1:0]          in_pc;
    logic [XLEN-1:0]          in_imm;
    logic [XLEN-1:0]          in_rs1;
    logic [XLEN-1:0]          in_rs2;
    logic [`ALU_OP_WIDTH-1:0] in_br_op;
    logic [1:0]               in_kind;
    logic                     kill;
    logic                     res_valid;
    logic                     res_taken;
    logic [XLEN-1:0]          res_link;
    logic                     misalign_err;
    logic                     redirect_valid;
    logic [XLEN-1:0]          redirect_pc;
    logic                     redirect_ready;
    logic                     flush;
    logic [CNT_W-1:0]         br_count;
    logic [CNT_W-1:0]         taken_count;

    modport master (
        output in_valid, in_pc, in_imm, in_rs1, in_rs2, in_br_op, in_kind,
               kill, redirect_ready,
        input  in_ready, res_valid, res_taken, res_link, misalign_err,
               redirect_valid, redirect_pc, flush, br_count, taken_count
    );

    modport slave (
        input  in_valid, in_pc, in_imm, in_rs1, in_rs2, in_br_op, in_kind,
               kill, redirect_ready,
        output in_ready, res_valid, res_taken, res_link, misalign_err,
               redirect_valid, redirect_pc, flush, br_count, taken_count
    );
endinterface

// File: rtl/branch_ctrl.sv
// Execute-stage branch/jump controller: resolves one control transfer at a time,
// then drives a redirect handshake to fetch followed by a timed pipeline flush.

module branch_cmp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]          a_i,
    input  logic [XLEN-1:0]          b_i,
    input  logic [`ALU_OP_WIDTH-1:0] op_i,
    output logic                     cond_o
);
    always_comb begin
        case (op_i)
            `ALU_OP_SEQ:  cond_o = (a_i == b_i);
            `ALU_OP_SNE:  cond_o = (a_i != b_i);
            `ALU_OP_SLT:  cond_o = ($signed(a_i) <  $signed(b_i));
            `ALU_OP_SGE:  cond_o = ($signed(a_i) >= $signed(b_i));
            `ALU_OP_SLTU: cond_o = (a_i <  b_i);
            `ALU_OP_SGEU: cond_o = (a_i >= b_i);
            default:      cond_o = 1'b0;
        endcase
    end
endmodule

module branch_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic         clk,
    input  logic         rst,
    branch_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EVAL  = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam int              FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]               state_q,    state_d;
    logic [XLEN-1:0]          pc_q,       pc_d;
    logic [XLEN-1:0]          imm_q,      imm_d;
    logic [XLEN-1:0]          rs1_q,      rs1_d;
    logic [XLEN-1:0]          rs2_q,      rs2_d;
    logic [`ALU_OP_WIDTH-1:0] op_q,       op_d;
    logic [1:0]               kind_q,     kind_d;
    logic [XLEN-1:0]          redirPc_q,  redirPc_d;
    logic [FC_W-1:0]          flushCnt_q, flushCnt_d;
    logic [CNT_W-1:0]         brCnt_q,    brCnt_d;
    logic [CNT_W-1:0]         takenCnt_q, takenCnt_d;

    logic            cond;
    logic            taken;
    logic            evalLive;
    logic [XLEN-1:0] jalrSum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .a_i    (rs1_q),
        .b_i    (rs2_q),
        .op_i   (op_q),
        .cond_o (cond)
    );

    // Reserved kind 3 falls through every term and resolves not-taken.
    assign jalrSum  = rs1_q + imm_q;
    assign target   = (kind_q == 2'd2) ? (jalrSum & {{(XLEN-1){1'b1}}, 1'b0}) : (pc_q + imm_q);
    assign taken    = (kind_q == 2'd1) || (kind_q == 2'd2) || ((kind_q == 2'd0) && cond);
    assign link     = pc_q + XLEN'(4);
    assign evalLive = (state_q == S_EVAL) && !bus.kill;

    assign bus.in_ready       = (state_q == S_IDLE);
    assign bus.res_valid      = evalLive;
    assign bus.res_taken      = evalLive && taken;
    assign bus.res_link       = evalLive ? link : '0;
    assign bus.misalign_err   = evalLive && taken && target[1];
    assign bus.redirect_valid = (state_q == S_REDIR);
    assign bus.redirect_pc    = redirPc_q;
    assign bus.flush          = (state_q == S_FLUSH);
    assign bus.br_count       = brCnt_q;
    assign bus.taken_count    = takenCnt_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        op_d       = op_q;
        kind_d     = kind_q;
        redirPc_d  = redirPc_q;
        flushCnt_d = flushCnt_q;
        brCnt_d    = brCnt_q;
        takenCnt_d = takenCnt_q;

        // kill overrides everything, including an accept offered in the same cycle.
        if (bus.kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        pc_d    = bus.in_pc;
                        imm_d   = bus.in_imm;
                        rs1_d   = bus.in_rs1;
                        rs2_d   = bus.in_rs2;
                        op_d    = bus.in_br_op;
                        kind_d  = bus.in_kind;
                        brCnt_d = (brCnt_q == CNT_MAX) ? brCnt_q : brCnt_q + 1'b1;
                        state_d = S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (taken && !target[1]) begin
                        takenCnt_d = (takenCnt_q == CNT_MAX) ? takenCnt_q : takenCnt_q + 1'b1;
                        redirPc_d  = target;
                        state_d    = S_REDIR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_REDIR: begin
                    if (bus.redirect_ready) begin
                        if (FLUSH_CYCLES == 0) begin
                            state_d = S_IDLE;
                        end else begin
                            flushCnt_d = FC_LOAD;
                            state_d    = S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flushCnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        flushCnt_d = flushCnt_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            op_q       <= '0;
            kind_q     <= '0;
            redirPc_q  <= '0;
            flushCnt_q <= '0;
            brCnt_q    <= '0;
            takenCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            op_q       <= op_d;
            kind_q     <= kind_d;
            redirPc_q  <= redirPc_d;
            flushCnt_q <= flushCnt_d;
            brCnt_q    <= brCnt_d;
            takenCnt_q <= takenCnt_d;
        end
    end
endmodule
